wb_button_reporter: RTL and testbench

- Wishbone controller stage that feeds the debug-button Wishbone device bus.
- Synchronises and debounces raw push-buttons and turns each debounced edge into a press/release event.
- Queues events in a small FIFO and emits each one as a single pipelined Wishbone write (controller side: cyc/stb/we/dat out; ack/err/rty/stall in; no address).

---
 rtl/wb_button_pkg.sv | 25 ++
 rtl/wb_button_reporter_if.sv | 23 ++
 rtl/button_debouncer.sv | 53 +++++
 rtl/wb_button_reporter.sv | 171 +++++++++++++++++
 tb/tb_wb_button_reporter.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_button_pkg.sv
// Shared types and event-field helpers for the button reporter.
package wb_button_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_WAIT    = 2'd2,
        ST_BACKOFF = 2'd3
    } wb_state_e;

    // Width of the button-index field; a single button still takes one bit.
    function automatic int idx_width(input int n_buttons);
        return (n_buttons <= 1) ? 1 : $clog2(n_buttons);
    endfunction

    // The press/release level always sits in the top data bit.
    function automatic int level_bit(input int dat_width);
        return dat_width - 1;
    endfunction

    function automatic int min1(input int v);
        return (v < 1) ? 1 : v;
    endfunction

endpackage

// File: rtl/wb_button_reporter_if.sv
// Controller-side pipelined Wishbone write bus (no address); names follow the controller view.
interface wb_button_reporter_if #(
    parameter int DAT_WIDTH = 8
);
    logic                 cyc_o;
    logic                 stb_o;
    logic                 we_o;
    logic [DAT_WIDTH-1:0] dat_o;
    logic                 ack_i;
    logic                 err_i;
    logic                 rty_i;
    logic                 stall_i;

    modport master (
        output cyc_o, stb_o, we_o, dat_o,
        input  ack_i, err_i, rty_i, stall_i
    );

    modport slave (
        input  cyc_o, stb_o, we_o, dat_o,
        output ack_i, err_i, rty_i, stall_i
    );
endinterface

// File: rtl/button_debouncer.sv
// One button: 2-flop synchroniser plus stability counter; a level change commits only when granted.
module button_debouncer
    import wb_button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    input  logic grant_i,
    output logic ready_o,
    output logic level_o
);
    localparam int CW = min1($clog2(DEBOUNCE_CYCLES));
    localparam logic [CW-1:0] THRESH = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          db_q, db_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          differ;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        differ  = sync2_q ^ db_q;
        ready_o = differ && (cnt_q == THRESH);
        level_o = ~db_q;
        cnt_d   = cnt_q;
        db_d    = db_q;
        if (!differ) begin
            cnt_d = '0;
        end else if (cnt_q != THRESH) begin
            cnt_d = cnt_q + 1'b1;
        end else if (grant_i) begin
            // Without a grant the counter parks at threshold until arbitration frees up.
            cnt_d = '0;
            db_d  = ~db_q;
        end
    end

endmodule

// File: rtl/wb_button_reporter.sv
// Debounced button edges become events, queued and written one per Wishbone cycle with retry/timeout.
module wb_button_reporter
    import wb_button_pkg::*;
#(
    parameter int N_BUTTONS       = 4,
    parameter int DAT_WIDTH       = 8,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int FIFO_DEPTH      = 4,
    parameter int MAX_RETRIES     = 3,
    parameter int TIMEOUT_CYCLES  = 255
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [N_BUTTONS-1:0] btn_i,
    wb_button_reporter_if.master wb,
    output logic                 overflow_o,
    output logic                 wr_err_o,
    output logic                 busy_o
);
    localparam int IDX_W = idx_width(N_BUTTONS);
    localparam int LVL   = level_bit(DAT_WIDTH);
    localparam int PTR_W = min1($clog2(FIFO_DEPTH));
    localparam int RTY_W = min1($clog2(MAX_RETRIES + 1));
    localparam int TMO_W = min1($clog2(TIMEOUT_CYCLES + 1));
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRIES);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    // Debouncers and commit arbitration
    logic [N_BUTTONS-1:0] ready, grant, new_lvl;
    logic                 push;
    logic [DAT_WIDTH-1:0] push_dat;

    for (genvar g = 0; g < N_BUTTONS; g++) begin : g_btn
        button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .btn_i   (btn_i[g]),
            .grant_i (grant[g]),
            .ready_o (ready[g]),
            .level_o (new_lvl[g])
        );
    end

    always_comb begin
        grant    = '0;
        push     = 1'b0;
        push_dat = '0;
        for (int i = 0; i < N_BUTTONS; i++) begin
            if (ready[i] && !push) begin
                grant[i]            = 1'b1;
                push                = 1'b1;
                push_dat[IDX_W-1:0] = IDX_W'(i);
                push_dat[LVL]       = new_lvl[i];
            end
        end
    end

    // Event FIFO; the extra pointer bit separates full from empty.
    logic [DAT_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W:0]       wr_ptr_q, rd_ptr_q;
    logic                 empty, full, pop, push_ok;
    logic [DAT_WIDTH-1:0] head;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign push_ok = push && (!full || pop);
    assign head    = mem_q[rd_ptr_q[PTR_W-1:0]];

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q[PTR_W-1:0]] <= push_dat;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Wishbone FSM
    wb_state_e        state_q, state_d;
    logic [RTY_W-1:0] retry_q, retry_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             overflow_q, wr_err_q, set_err, sample;
    logic             cyc, stb;
    logic [DAT_WIDTH-1:0] dat;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= ST_IDLE;
            retry_q    <= '0;
            tmo_q      <= '0;
            overflow_q <= 1'b0;
            wr_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            retry_q    <= retry_d;
            tmo_q      <= tmo_d;
            overflow_q <= overflow_q | (push && full && !pop);
            wr_err_q   <= wr_err_q | set_err;
        end
    end

    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        tmo_d   = tmo_q;
        pop     = 1'b0;
        set_err = 1'b0;
        // Terminations count only on the acceptance cycle or while waiting.
        sample  = ((state_q == ST_REQ) && !wb.stall_i) || (state_q == ST_WAIT);
        case (state_q)
            ST_IDLE: begin
                if (!empty) begin
                    state_d = ST_REQ;
                    retry_d = '0;
                end
            end
            ST_BACKOFF: state_d = ST_REQ;
            default: begin
                if (sample) begin
                    if (wb.err_i) begin
                        pop     = 1'b1;
                        set_err = 1'b1;
                        state_d = ST_IDLE;
                    end else if (wb.rty_i) begin
                        if (retry_q < RTY_MAX) begin
                            retry_d = retry_q + 1'b1;
                            state_d = ST_BACKOFF;
                        end else begin
                            pop     = 1'b1;
                            set_err = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end else if (wb.ack_i) begin
                        pop     = 1'b1;
                        state_d = ST_IDLE;
                    end else if (state_q == ST_REQ) begin
                        state_d = ST_WAIT;
                        tmo_d   = '0;
                    end else if (tmo_q == TMO_LAST) begin
                        pop     = 1'b1;
                        set_err = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        tmo_d = tmo_q + 1'b1;
                    end
                end
            end
        endcase
    end

    always_comb begin
        cyc = (state_q == ST_REQ) || (state_q == ST_WAIT);
        stb = (state_q == ST_REQ);
        dat = cyc ? head : '0;
    end

    assign wb.cyc_o   = cyc;
    assign wb.stb_o   = stb;
    assign wb.we_o    = cyc;
    assign wb.dat_o   = dat;
    assign overflow_o = overflow_q;
    assign wr_err_o   = wr_err_q;
    assign busy_o     = !empty || cyc;

endmodule

// File: tb/tb_wb_button_reporter.sv
// Directed bench: table of single-button edges plus hand sequences for bounce, stall, retry, timeout, overflow.
module tb_wb_button_reporter;
    localparam int NB = 4;
    localparam int DW = 8;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic [NB-1:0] btn_i = '0;
    logic          overflow_o, wr_err_o, busy_o;

    wb_button_reporter_if #(.DAT_WIDTH(DW)) wb ();

    wb_button_reporter #(
        .N_BUTTONS(NB), .DAT_WIDTH(DW), .DEBOUNCE_CYCLES(16),
        .FIFO_DEPTH(4), .MAX_RETRIES(3), .TIMEOUT_CYCLES(255)
    ) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .btn_i      (btn_i),
        .wb         (wb.master),
        .overflow_o (overflow_o),
        .wr_err_o   (wr_err_o),
        .busy_o     (busy_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [NB-1:0] btn;
        logic [DW-1:0] dat;
    } vec_t;
    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_cyc(input int limit, output int n, output bit ok);
        n  = 0;
        ok = 1'b0;
        while (n < limit && !ok) begin
            @(negedge clk_i);
            n++;
            if (wb.cyc_o === 1'b1) ok = 1'b1;
        end
    endtask

    // Waits for a cycle, checks the word, lets it go to WAIT and acks there.
    task automatic do_write(input string name, input logic [DW-1:0] exp, input bit chk_lat);
        int n;
        bit ok;
        wait_cyc(200, n, ok);
        check({name, " cyc"}, 32'(ok), 32'd1);
        if (ok) begin
            if (chk_lat) begin
                checks++;
                if (n < 19 || n > 20) begin
                    errors++;
                    $display("FAIL %s latency: got %0d cycles expected 19..20", name, n);
                end
            end
            check({name, " stb"}, 32'(wb.stb_o), 32'd1);
            check({name, " we"},  32'(wb.we_o),  32'd1);
            check({name, " dat"}, 32'(wb.dat_o), 32'(exp));
            @(negedge clk_i);
            check({name, " wait cyc"}, 32'(wb.cyc_o), 32'd1);
            check({name, " wait stb"}, 32'(wb.stb_o), 32'd0);
            wb.ack_i = 1'b1;
            @(negedge clk_i);
            wb.ack_i = 1'b0;
            check({name, " cyc drop"}, 32'(wb.cyc_o), 32'd0);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    initial begin
        int  n;
        bit  ok;
        int  spurious;

        wb.ack_i = 1'b0; wb.err_i = 1'b0; wb.rty_i = 1'b0; wb.stall_i = 1'b0;
        vecs[0] = '{4'b0100, 8'h82};
        vecs[1] = '{4'b0000, 8'h02};
        vecs[2] = '{4'b0001, 8'h80};
        vecs[3] = '{4'b0000, 8'h00};
        vecs[4] = '{4'b1000, 8'h83};
        vecs[5] = '{4'b0000, 8'h03};
        vecs[6] = '{4'b0010, 8'h81};
        vecs[7] = '{4'b0000, 8'h01};

        #1 rst_i = 1'b0;
        repeat (2) @(negedge clk_i);
        check("rst cyc", 32'(wb.cyc_o), 0);
        check("rst stb", 32'(wb.stb_o), 0);
        check("rst we",  32'(wb.we_o),  0);
        check("rst dat", 32'(wb.dat_o), 0);
        check("rst overflow", 32'(overflow_o), 0);
        check("rst wr_err",   32'(wr_err_o),   0);
        check("rst busy",     32'(busy_o),     0);
        rst_i = 1'b1;

        for (int v = 0; v < 8; v++) begin
            @(negedge clk_i);
            btn_i = vecs[v].btn;
            do_write($sformatf("vec%0d", v), vecs[v].dat, 1'b1);
        end

        // Bouncing input never stays stable long enough to commit.
        spurious = 0;
        for (int s = 0; s < 12; s++) begin
            @(negedge clk_i);
            btn_i[0] = (s % 2 == 0);
            for (int c = 0; c < 4; c++) begin
                @(negedge clk_i);
                if (wb.cyc_o) spurious++;
            end
        end
        check("bounce no write", 32'(spurious), 0);
        @(negedge clk_i);
        btn_i[0] = 1'b1;
        do_write("bounce press", 8'h80, 1'b1);
        @(negedge clk_i);
        btn_i[0] = 1'b0;
        do_write("bounce release", 8'h00, 1'b1);

        @(negedge clk_i);
        btn_i = 4'b1010;
        do_write("dual first", 8'h81, 1'b1);
        do_write("dual second", 8'h83, 1'b0);
        @(negedge clk_i);
        btn_i = 4'b0000;
        do_write("dual rel first", 8'h01, 1'b1);
        do_write("dual rel second", 8'h03, 1'b0);

        // Stalled strobe, then ack on the acceptance cycle.
        wb.stall_i = 1'b1;
        @(negedge clk_i);
        btn_i = 4'b0100;
        wait_cyc(200, n, ok);
        check("stall cyc", 32'(ok), 1);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("stall stb%0d", k), 32'(wb.stb_o), 1);
            check($sformatf("stall dat%0d", k), 32'(wb.dat_o), 32'h82);
            if (k < 3) @(negedge clk_i);
        end
        wb.stall_i = 1'b0;
        wb.ack_i   = 1'b1;
        @(negedge clk_i);
        wb.ack_i = 1'b0;
        check("stall no wait", 32'(wb.cyc_o), 0);
        check("stall busy", 32'(busy_o), 0);
        @(negedge clk_i);
        btn_i = 4'b0000;
        do_write("stall release", 8'h02, 1'b1);

        // No termination at all: abort after the timeout.
        check("tmo wr_err before", 32'(wr_err_o), 0);
        @(negedge clk_i);
        btn_i = 4'b1000;
        wait_cyc(200, n, ok);
        check("tmo cyc", 32'(ok), 1);
        @(negedge clk_i);
        n = 0;
        while (wb.cyc_o && n < 400) begin
            n++;
            @(negedge clk_i);
        end
        check("tmo wait cycles", 32'(n), 255);
        check("tmo wr_err", 32'(wr_err_o), 1);
        check("tmo busy", 32'(busy_o), 0);
        btn_i = 4'b0000;
        do_write("tmo release", 8'h03, 1'b0);

        pulse_reset();
        check("reset clears wr_err", 32'(wr_err_o), 0);

        // Retry on every attempt.
        @(negedge clk_i);
        btn_i = 4'b0010;
        wait_cyc(200, n, ok);
        check("rty cyc", 32'(ok), 1);
        for (int a = 0; a < 4; a++) begin
            check($sformatf("rty att%0d stb", a), 32'(wb.stb_o), 1);
            check($sformatf("rty att%0d dat", a), 32'(wb.dat_o), 32'h81);
            check($sformatf("rty att%0d wr_err", a), 32'(wr_err_o), 0);
            wb.rty_i = 1'b1;
            @(negedge clk_i);
            wb.rty_i = 1'b0;
            check($sformatf("rty att%0d cyc low", a), 32'(wb.cyc_o), 0);
            if (a < 3) begin
                @(negedge clk_i);
                check($sformatf("rty att%0d backoff 1", a), 32'(wb.cyc_o), 1);
            end
        end
        check("rty wr_err", 32'(wr_err_o), 1);
        check("rty fifo advanced", 32'(busy_o), 0);
        @(negedge clk_i);
        btn_i = 4'b0000;
        do_write("rty release", 8'h01, 1'b1);

        // Overflow under a permanent stall, then asynchronous reset mid-REQ.
        wb.stall_i = 1'b1;
        @(negedge clk_i);
        btn_i = 4'b1111;
        repeat (30) @(negedge clk_i);
        check("ovf cyc", 32'(wb.cyc_o), 1);
        check("ovf head", 32'(wb.dat_o), 32'h80);
        check("ovf not yet", 32'(overflow_o), 0);
        check("ovf busy", 32'(busy_o), 1);
        btn_i = 4'b1100;
        repeat (30) @(negedge clk_i);
        check("ovf set", 32'(overflow_o), 1);
        check("ovf stb held", 32'(wb.stb_o), 1);
        check("ovf head held", 32'(wb.dat_o), 32'h80);
        #2 rst_i = 1'b0;
        #1;
        check("async rst cyc", 32'(wb.cyc_o), 0);
        check("async rst stb", 32'(wb.stb_o), 0);
        check("async rst dat", 32'(wb.dat_o), 0);
        check("async rst overflow", 32'(overflow_o), 0);
        check("async rst busy", 32'(busy_o), 0);
        btn_i      = 4'b0000;
        wb.stall_i = 1'b0;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b1;
        repeat (30) @(negedge clk_i);
        check("post rst idle", 32'(busy_o), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
